// File: rtl/ppu_strip_pkg.sv
// Shared constants and FSM encoding for the payload padding strip unit.
package ppu_strip_pkg;

  localparam int PPU_PAYLOAD_LEN = 8640;
  localparam int PPU_PAD_LEN     = 960;
  localparam int PPU_CNT_W       = 14;
  localparam int PPU_ERR_W       = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_PAD   = 2'd2,
    ST_DRAIN = 2'd3
  } ppu_state_t;

endpackage

// File: rtl/ppu_pad_buf.sv
// Copy of the first PAD_LEN data bits of the current frame.
// Synchronous write, asynchronous read so the padding bit can be compared
// in the same cycle it arrives; small enough for distributed RAM.
module ppu_pad_buf
  import ppu_strip_pkg::*;
#(
  parameter int DEPTH = PPU_PAD_LEN,
  parameter int AW    = $clog2(PPU_PAD_LEN)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wdata,
  input  logic [AW-1:0] raddr,
  output logic          rdata
);

  logic r_mem [DEPTH];

  // Store one data bit per write; contents are deliberately never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/ppu_strip.sv
// Strips the padding tail from a received payload frame, forwards the data
// bits with one cycle of latency and counts padding bits that disagree with
// the stored copy of the leading data bits.
module ppu_strip
  import ppu_strip_pkg::*;
#(
  parameter int PAYLOAD_LEN = PPU_PAYLOAD_LEN,
  parameter int PAD_LEN     = PPU_PAD_LEN,
  parameter int CNT_W       = PPU_CNT_W,
  parameter int ERR_W       = PPU_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             di,
  input  logic             di_vld,
  output logic             do_bit,
  output logic             do_vld,
  output logic             do_last,
  output logic [ERR_W-1:0] pad_err_cnt,
  output logic             pad_chk_vld,
  output logic             frame_err
);

  localparam int AW = (PAD_LEN > 1) ? $clog2(PAD_LEN) : 1;

  localparam logic [CNT_W-1:0] C_PAY_BASE  = CNT_W'(PAYLOAD_LEN);
  localparam logic [CNT_W-1:0] C_LAST_DATA = CNT_W'(PAYLOAD_LEN - 1);
  localparam logic [CNT_W-1:0] C_LAST_PAD  = CNT_W'(PAYLOAD_LEN + PAD_LEN - 1);
  localparam logic [CNT_W-1:0] C_FRAME_END = CNT_W'(PAYLOAD_LEN + PAD_LEN);
  localparam logic [CNT_W-1:0] C_PAD_LEN   = CNT_W'(PAD_LEN);

  ppu_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [ERR_W-1:0] r_acc;

  logic [CNT_W-1:0] w_k;
  logic [CNT_W-1:0] w_pidx;
  logic             w_we;
  logic             w_rdata;
  logic             w_mism;
  logic [ERR_W-1:0] w_acc_next;

  // The first bit of a frame is taken in IDLE, where the counter still
  // holds the previous frame's value, so its index is forced to 0.
  assign w_k        = (r_state == ST_IDLE) ? '0 : r_cnt;
  assign w_pidx     = r_cnt - C_PAY_BASE;
  assign w_we       = di_vld && (r_state == ST_IDLE || r_state == ST_DATA) && (w_k < C_PAD_LEN);
  assign w_mism     = di ^ w_rdata;
  assign w_acc_next = r_acc + ERR_W'(w_mism);

  ppu_pad_buf #(
    .DEPTH (PAD_LEN),
    .AW    (AW)
  ) u_pad_buf (
    .clk   (clk),
    .we    (w_we),
    .waddr (AW'(w_k)),
    .wdata (di),
    .raddr (AW'(w_pidx)),
    .rdata (w_rdata)
  );

  // Frame FSM, bit counter, mismatch accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      do_bit      <= 1'b0;
      do_vld      <= 1'b0;
      do_last     <= 1'b0;
      pad_err_cnt <= '0;
      pad_chk_vld <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      do_vld      <= 1'b0;
      do_last     <= 1'b0;
      pad_chk_vld <= 1'b0;
      frame_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (di_vld) begin
            do_bit  <= di;
            do_vld  <= 1'b1;
            r_acc   <= '0;
            r_cnt   <= CNT_W'(1);
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (di_vld) begin
            do_bit <= di;
            do_vld <= 1'b1;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (r_cnt == C_LAST_DATA) begin
              do_last <= 1'b1;
              r_state <= ST_PAD;
            end
          end else begin
            frame_err <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        ST_PAD: begin
          if (r_cnt == C_FRAME_END) begin
            // Frame complete: a still-high valid here is the first overrun bit.
            r_state <= di_vld ? ST_DRAIN : ST_IDLE;
          end else if (di_vld) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == C_LAST_PAD) begin
              pad_err_cnt <= w_acc_next;
              pad_chk_vld <= 1'b1;
            end
          end else begin
            frame_err <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (!di_vld) begin
            frame_err <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_strip.sv
// Directed bench for ppu_strip: clean, corrupted, truncated, overrun and
// reset-interrupted frames at the full frame size.
module tb_ppu_strip;
  import ppu_strip_pkg::*;

  localparam int PL  = PPU_PAYLOAD_LEN;
  localparam int PD  = PPU_PAD_LEN;
  localparam int TOT = PL + PD;

  logic       clk = 1'b0;
  logic       rst;
  logic       di;
  logic       di_vld;
  logic       do_bit;
  logic       do_vld;
  logic       do_last;
  logic [9:0] pad_err_cnt;
  logic       pad_chk_vld;
  logic       frame_err;

  int n_assert = 0;
  int n_fail   = 0;

  logic fbits [TOT + 64];

  int s_vld, s_bad, s_last, s_last_at, s_chk, s_chk_at, s_chk_val, s_ferr, s_ferr_at;

  ppu_strip dut (
    .clk         (clk),
    .rst         (rst),
    .di          (di),
    .di_vld      (di_vld),
    .do_bit      (do_bit),
    .do_vld      (do_vld),
    .do_last     (do_last),
    .pad_err_cnt (pad_err_cnt),
    .pad_chk_vld (pad_chk_vld),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    s_vld = 0; s_bad = 0; s_last = 0; s_last_at = -1; s_chk = 0;
    s_chk_at = -1; s_chk_val = -1; s_ferr = 0; s_ferr_at = -1;
  endtask

  // Accumulate what the DUT showed after the edge that sampled bit c.
  task automatic sample(input int c);
    if (do_vld === 1'b1) begin
      s_vld++;
      if (c >= PL) s_bad++;
      else if (do_bit !== fbits[c]) s_bad++;
    end
    if (do_last === 1'b1) begin s_last++; s_last_at = c; end
    if (pad_chk_vld === 1'b1) begin s_chk++; s_chk_at = c; s_chk_val = int'(pad_err_cnt); end
    if (frame_err === 1'b1) begin s_ferr++; s_ferr_at = c; end
  endtask

  // mode 0: clean pad, 1: five flipped pad bits, 2: all pad bits inverted.
  task automatic make_frame(input int mode);
    logic f;
    for (int k = 0; k < PL; k++) fbits[k] = 1'($urandom_range(0, 1));
    for (int j = 0; j < PD; j++) begin
      f = (mode == 2) || (mode == 1 && (j == 0 || j == 1 || j == 480 || j == 958 || j == 959));
      fbits[PL + j] = fbits[j] ^ f;
    end
    for (int k = TOT; k < TOT + 64; k++) fbits[k] = 1'($urandom_range(0, 1));
  endtask

  task automatic run_frame(input int nbits, input int tail);
    clear_stats();
    for (int c = 0; c < nbits; c++) begin
      di = fbits[c]; di_vld = 1'b1;
      step();
      sample(c);
    end
    for (int t = 0; t < tail; t++) begin
      di = 1'b0; di_vld = 1'b0;
      step();
      sample(nbits + t);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; di = 1'b0; di_vld = 1'b0;
    step(); step();
    n_assert++;
    if ({do_bit, do_vld, do_last, pad_chk_vld, frame_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {do_bit, do_vld, do_last, pad_chk_vld, frame_err});
    end
    n_assert++;
    if (pad_err_cnt !== 10'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d expected 0", pad_err_cnt);
    end
    rst = 1'b0;
    step();
    $display("reset: flags=%b cnt=%0d", {do_bit, do_vld, do_last, pad_chk_vld, frame_err}, pad_err_cnt);
  endtask

  task automatic test_clean_frame(input string tag);
    make_frame(0);
    run_frame(TOT, 1);
    $display("%s: vld=%0d bad=%0d last@%0d chk=%0d@%0d val=%0d ferr=%0d", tag, s_vld, s_bad, s_last_at, s_chk, s_chk_at, s_chk_val, s_ferr);
    n_assert++; if (s_vld != PL) begin n_fail++; $display("FAIL %s do_vld count: got %0d expected %0d", tag, s_vld, PL); end
    n_assert++; if (s_bad != 0) begin n_fail++; $display("FAIL %s do data: got %0d bad bits expected 0", tag, s_bad); end
    n_assert++; if (s_last != 1 || s_last_at != PL - 1) begin n_fail++; $display("FAIL %s do_last: got %0d at %0d expected 1 at %0d", tag, s_last, s_last_at, PL - 1); end
    n_assert++; if (s_chk != 1 || s_chk_at != TOT - 1) begin n_fail++; $display("FAIL %s pad_chk_vld: got %0d at %0d expected 1 at %0d", tag, s_chk, s_chk_at, TOT - 1); end
    n_assert++; if (s_chk_val != 0) begin n_fail++; $display("FAIL %s pad_err_cnt: got %0d expected 0", tag, s_chk_val); end
    n_assert++; if (s_ferr != 0) begin n_fail++; $display("FAIL %s frame_err: got %0d pulses expected 0", tag, s_ferr); end
    n_assert++; if (do_bit !== fbits[PL - 1]) begin n_fail++; $display("FAIL %s do hold: got %b expected %b", tag, do_bit, fbits[PL - 1]); end
  endtask

  task automatic test_flips();
    make_frame(1);
    run_frame(TOT, 1);
    $display("flips: vld=%0d bad=%0d chk=%0d val=%0d ferr=%0d", s_vld, s_bad, s_chk, s_chk_val, s_ferr);
    n_assert++; if (s_vld != PL || s_bad != 0) begin n_fail++; $display("FAIL flips payload: got vld=%0d bad=%0d expected vld=%0d bad=0", s_vld, s_bad, PL); end
    n_assert++; if (s_chk != 1 || s_chk_val != 5) begin n_fail++; $display("FAIL flips pad_err_cnt: got %0d (chk=%0d) expected 5", s_chk_val, s_chk); end
    n_assert++; if (s_ferr != 0) begin n_fail++; $display("FAIL flips frame_err: got %0d expected 0", s_ferr); end
  endtask

  task automatic test_back_to_back();
    make_frame(2);
    run_frame(TOT, 1);
    $display("invert: vld=%0d chk=%0d@%0d val=%0d ferr=%0d", s_vld, s_chk, s_chk_at, s_chk_val, s_ferr);
    n_assert++; if (s_chk != 1 || s_chk_val != PD) begin n_fail++; $display("FAIL invert pad_err_cnt: got %0d (chk=%0d) expected %0d", s_chk_val, s_chk, PD); end
    n_assert++; if (s_ferr != 0) begin n_fail++; $display("FAIL invert frame_err: got %0d expected 0", s_ferr); end
    test_clean_frame("b2b_clean");
  endtask

  task automatic test_truncate();
    make_frame(0);
    run_frame(5000, 3);
    $display("truncate: vld=%0d bad=%0d last=%0d chk=%0d ferr=%0d@%0d", s_vld, s_bad, s_last, s_chk, s_ferr, s_ferr_at);
    n_assert++; if (s_vld != 5000 || s_bad != 0) begin n_fail++; $display("FAIL trunc payload: got vld=%0d bad=%0d expected vld=5000 bad=0", s_vld, s_bad); end
    n_assert++; if (s_last != 0) begin n_fail++; $display("FAIL trunc do_last: got %0d expected 0", s_last); end
    n_assert++; if (s_chk != 0) begin n_fail++; $display("FAIL trunc pad_chk_vld: got %0d expected 0", s_chk); end
    n_assert++; if (s_ferr != 1 || s_ferr_at != 5000) begin n_fail++; $display("FAIL trunc frame_err: got %0d at %0d expected 1 at 5000", s_ferr, s_ferr_at); end
    test_clean_frame("trunc_next");
  endtask

  task automatic test_overrun();
    make_frame(2);
    run_frame(TOT + 10, 3);
    $display("overrun: vld=%0d bad=%0d last@%0d chk=%0d@%0d val=%0d ferr=%0d@%0d", s_vld, s_bad, s_last_at, s_chk, s_chk_at, s_chk_val, s_ferr, s_ferr_at);
    n_assert++; if (s_vld != PL || s_bad != 0) begin n_fail++; $display("FAIL overrun payload: got vld=%0d bad=%0d expected vld=%0d bad=0", s_vld, s_bad, PL); end
    n_assert++; if (s_last != 1 || s_last_at != PL - 1) begin n_fail++; $display("FAIL overrun do_last: got %0d at %0d expected 1 at %0d", s_last, s_last_at, PL - 1); end
    n_assert++; if (s_chk != 1 || s_chk_at != TOT - 1 || s_chk_val != PD) begin n_fail++; $display("FAIL overrun pad_chk: got %0d at %0d val %0d expected 1 at %0d val %0d", s_chk, s_chk_at, s_chk_val, TOT - 1, PD); end
    n_assert++; if (s_ferr != 1 || s_ferr_at != TOT + 10) begin n_fail++; $display("FAIL overrun frame_err: got %0d at %0d expected 1 at %0d", s_ferr, s_ferr_at, TOT + 10); end
  endtask

  task automatic test_reset_mid_frame();
    n_assert++; if (pad_err_cnt !== 10'(PD)) begin n_fail++; $display("FAIL midrst pre_cnt: got %0d expected %0d", pad_err_cnt, PD); end
    make_frame(0);
    run_frame(9000, 0);
    rst = 1'b1; di_vld = 1'b0; di = 1'b0;
    step();
    $display("midrst: flags=%b cnt=%0d", {do_bit, do_vld, do_last, pad_chk_vld, frame_err}, pad_err_cnt);
    n_assert++; if ({do_bit, do_vld, do_last, pad_chk_vld, frame_err} !== 5'b0) begin n_fail++; $display("FAIL midrst flags: got %b expected 00000", {do_bit, do_vld, do_last, pad_chk_vld, frame_err}); end
    n_assert++; if (pad_err_cnt !== 10'd0) begin n_fail++; $display("FAIL midrst cnt: got %0d expected 0", pad_err_cnt); end
    rst = 1'b0;
    clear_stats();
    for (int t = 0; t < 3; t++) begin step(); sample(TOT + t); end
    n_assert++; if (s_chk != 0 || s_ferr != 0 || s_vld != 0) begin n_fail++; $display("FAIL midrst after: got chk=%0d ferr=%0d vld=%0d expected all 0", s_chk, s_ferr, s_vld); end
    test_clean_frame("midrst_next");
  endtask

  initial begin
    test_reset();
    test_clean_frame("clean");
    test_flips();
    test_back_to_back();
    test_truncate();
    test_overrun();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
